load_store_unit: RTL and testbench



---
 rtl/riscv_pkg.sv | 33 +++
 rtl/lsu_lane_align.sv | 48 ++++
 rtl/load_store_unit.sv | 151 +++++++++++++++
 tb/tb_load_store_unit.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V load/store definitions: funct3 width codes,
// fault-cause encoding and the load/store unit state set.
package riscv_pkg;

    localparam logic [2:0] LOAD_BYTE          = 3'b000;
    localparam logic [2:0] LOAD_HALF          = 3'b001;
    localparam logic [2:0] LOAD_WORD          = 3'b010;
    localparam logic [2:0] LOAD_BYTE_UNSIGNED = 3'b100;
    localparam logic [2:0] LOAD_HALF_UNSIGNED = 3'b101;

    localparam logic [2:0] STORE_BYTE = 3'b000;
    localparam logic [2:0] STORE_HALF = 3'b001;
    localparam logic [2:0] STORE_WORD = 3'b010;

    localparam logic [2:0] MEM_MODE_WORD = 3'b010;

    typedef enum logic [1:0] {
        CAUSE_NONE       = 2'b00,
        CAUSE_MISALIGNED = 2'b01,
        CAUSE_FUNCT3     = 2'b10,
        CAUSE_RANGE      = 2'b11
    } fault_cause_e;

    typedef enum logic [2:0] {
        LSU_IDLE,
        LSU_LOAD,
        LSU_RMW_READ,
        LSU_WRITE,
        LSU_RESP,
        LSU_FAULT
    } lsu_state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Lane helper: extracts and extends a load lane, or merges a store lane.
// Ports: i_Funct3/i_Offset select lane; i_MemWord, i_StoreData in;
// o_LoadValue extended load, o_MergedWord read-modify-write word.
module lsu_lane_align
    import riscv_pkg::*;
(
    input  logic [2:0]  i_Funct3,
    input  logic [1:0]  i_Offset,
    input  logic [31:0] i_MemWord,
    input  logic [31:0] i_StoreData,
    output logic [31:0] o_LoadValue,
    output logic [31:0] o_MergedWord
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [4:0]  byte_shift;
    logic [4:0]  half_shift;

    always_comb begin
        byte_shift = {i_Offset, 3'b000};
        half_shift = {i_Offset[1], 4'b0000};
        byte_lane  = 8'(i_MemWord >> byte_shift);
        half_lane  = 16'(i_MemWord >> half_shift);

        o_LoadValue = i_MemWord;
        unique case (i_Funct3)
            LOAD_BYTE:
                o_LoadValue = {{24{byte_lane[7]}}, byte_lane};
            LOAD_HALF:
                o_LoadValue = {{16{half_lane[15]}}, half_lane};
            LOAD_BYTE_UNSIGNED:
                o_LoadValue = {24'h0, byte_lane};
            LOAD_HALF_UNSIGNED:
                o_LoadValue = {16'h0, half_lane};
            default:
                o_LoadValue = i_MemWord;
        endcase

        o_MergedWord = i_MemWord;
        if (i_Funct3 == STORE_BYTE) begin
            o_MergedWord[byte_shift +: 8] = i_StoreData[7:0];
        end else if (i_Funct3 == STORE_HALF) begin
            o_MergedWord[half_shift +: 16] = i_StoreData[15:0];
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store at a time, RMW for sub-word stores.
// Ports: i_Valid/o_Ready request, o_Done/o_Fault/o_LoadData response, o_Mem* to memory.
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int unsigned P_MEM_BYTES = 32768
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic        i_Valid,
    output logic        o_Ready,
    input  logic        i_IsStore,
    input  logic [2:0]  i_Funct3,
    input  logic [31:0] i_Address,
    input  logic [31:0] i_StoreData,
    output logic        o_Done,
    output logic [31:0] o_LoadData,
    output logic        o_Fault,
    output logic [1:0]  o_FaultCause,
    output logic        o_MemReadEnable,
    output logic        o_MemWriteEnable,
    output logic [31:0] o_MemAddress,
    output logic [31:0] o_MemDataOut,
    output logic [2:0]  o_MemMode,
    input  logic [31:0] i_MemDataIn
);

    lsu_state_e   state_q, state_d;
    fault_cause_e cause_q, cause_d;
    logic         is_store_q, is_store_d;
    logic [2:0]   funct3_q, funct3_d;
    logic [31:0]  addr_q, addr_d;
    logic [31:0]  sdata_q, sdata_d;
    logic [31:0]  merged_q, merged_d;
    logic [31:0]  load_data_q, load_data_d;

    logic [31:0] lane_load;
    logic [31:0] lane_merged;
    logic        bad_funct3;
    logic        misaligned;
    logic        out_of_range;

    lsu_lane_align u_align (
        .i_Funct3    (funct3_q),
        .i_Offset    (addr_q[1:0]),
        .i_MemWord   (i_MemDataIn),
        .i_StoreData (sdata_q),
        .o_LoadValue (lane_load),
        .o_MergedWord(lane_merged)
    );

    // Width checks below assume funct3 already passed the validity check.
    always_comb begin
        if (i_IsStore) begin
            bad_funct3 = (i_Funct3 >= 3'b011);
        end else begin
            bad_funct3 = (i_Funct3 == 3'b011) || (i_Funct3[2:1] == 2'b11);
        end
        misaligned = ((i_Funct3[1:0] == 2'b01) && i_Address[0])
                   || ((i_Funct3[1:0] == 2'b10) && (i_Address[1:0] != 2'b00));
        out_of_range = (i_Address >= P_MEM_BYTES);
    end

    always_comb begin
        state_d     = state_q;
        cause_d     = cause_q;
        is_store_d  = is_store_q;
        funct3_d    = funct3_q;
        addr_d      = addr_q;
        sdata_d     = sdata_q;
        merged_d    = merged_q;
        load_data_d = load_data_q;

        unique case (state_q)
            LSU_IDLE: begin
                if (i_Valid && o_Ready) begin
                    is_store_d = i_IsStore;
                    funct3_d   = i_Funct3;
                    addr_d     = i_Address;
                    sdata_d    = i_StoreData;
                    cause_d    = CAUSE_NONE;
                    if (bad_funct3) begin
                        cause_d = CAUSE_FUNCT3;
                        state_d = LSU_FAULT;
                    end else if (misaligned) begin
                        cause_d = CAUSE_MISALIGNED;
                        state_d = LSU_FAULT;
                    end else if (out_of_range) begin
                        cause_d = CAUSE_RANGE;
                        state_d = LSU_FAULT;
                    end else if (!i_IsStore) begin
                        state_d = LSU_LOAD;
                    end else if (i_Funct3 == STORE_WORD) begin
                        state_d = LSU_WRITE;
                    end else begin
                        state_d = LSU_RMW_READ;
                    end
                end
            end
            LSU_LOAD: begin
                load_data_d = lane_load;
                state_d     = LSU_RESP;
            end
            LSU_RMW_READ: begin
                merged_d = lane_merged;
                state_d  = LSU_WRITE;
            end
            LSU_WRITE: state_d = LSU_RESP;
            LSU_RESP:  state_d = LSU_IDLE;
            LSU_FAULT: state_d = LSU_IDLE;
            default:   state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q     <= LSU_IDLE;
            cause_q     <= CAUSE_NONE;
            is_store_q  <= 1'b0;
            funct3_q    <= 3'b000;
            addr_q      <= 32'h0;
            sdata_q     <= 32'h0;
            merged_q    <= 32'h0;
            load_data_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            cause_q     <= cause_d;
            is_store_q  <= is_store_d;
            funct3_q    <= funct3_d;
            addr_q      <= addr_d;
            sdata_q     <= sdata_d;
            merged_q    <= merged_d;
            load_data_q <= load_data_d;
        end
    end

    // Enables come straight from the state flop so reset kills them at once.
    always_comb begin
        o_Ready          = (state_q == LSU_IDLE) && !i_Reset;
        o_Done           = (state_q == LSU_RESP) || (state_q == LSU_FAULT);
        o_Fault          = (state_q == LSU_FAULT);
        o_FaultCause     = cause_q;
        o_LoadData       = load_data_q;
        o_MemReadEnable  = (state_q == LSU_LOAD) || (state_q == LSU_RMW_READ);
        o_MemWriteEnable = (state_q == LSU_WRITE);
        o_MemAddress     = {addr_q[31:2], 2'b00};
        o_MemMode        = MEM_MODE_WORD;
        o_MemDataOut     = (funct3_q == STORE_WORD) ? sdata_q : merged_q;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: vector table, reset abort,
// back-to-back and random requests against a reference model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_Valid = 1'b0;
    logic        o_Ready;
    logic        i_IsStore = 1'b0;
    logic [2:0]  i_Funct3 = 3'b0;
    logic [31:0] i_Address = 32'h0;
    logic [31:0] i_StoreData = 32'h0;
    logic        o_Done;
    logic [31:0] o_LoadData;
    logic        o_Fault;
    logic [1:0]  o_FaultCause;
    logic        o_MemReadEnable;
    logic        o_MemWriteEnable;
    logic [31:0] o_MemAddress;
    logic [31:0] o_MemDataOut;
    logic [2:0]  o_MemMode;
    logic [31:0] i_MemDataIn;

    logic [31:0] mem [0:8191];

    int total = 0;
    int bad = 0;
    int both_hi = 0;
    int accepts = 0;
    int ready_busy = 0;
    int nreq = 0;
    logic [31:0] last_ld = 32'h0;

    always #5 clk = ~clk;

    assign i_MemDataIn = mem[o_MemAddress[14:2]];

    load_store_unit #(.P_MEM_BYTES(32768)) dut (
        .i_Clock         (clk),
        .i_Reset         (rst),
        .i_Valid         (i_Valid),
        .o_Ready         (o_Ready),
        .i_IsStore       (i_IsStore),
        .i_Funct3        (i_Funct3),
        .i_Address       (i_Address),
        .i_StoreData     (i_StoreData),
        .o_Done          (o_Done),
        .o_LoadData      (o_LoadData),
        .o_Fault         (o_Fault),
        .o_FaultCause    (o_FaultCause),
        .o_MemReadEnable (o_MemReadEnable),
        .o_MemWriteEnable(o_MemWriteEnable),
        .o_MemAddress    (o_MemAddress),
        .o_MemDataOut    (o_MemDataOut),
        .o_MemMode       (o_MemMode),
        .i_MemDataIn     (i_MemDataIn)
    );

    always @(negedge clk) begin
        if (o_MemReadEnable && o_MemWriteEnable) both_hi <= both_hi + 1;
        if (i_Valid && o_Ready) accepts <= accepts + 1;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Behavioural model from the architectural rules.
    function automatic void ref_model(
        input  logic st, input logic [2:0] f3,
        input  logic [31:0] a, input logic [31:0] sd,
        input  logic [31:0] word, input logic [31:0] prev,
        output int lat, output logic flt, output logic [1:0] cs,
        output logic [31:0] ld, output logic [31:0] nword, output int nw);
        int unsigned sz, off;
        logic [31:0] full, mask, lane;
        bit bf;
        bf = st ? (f3 >= 3) : (f3 == 3 || f3 == 6 || f3 == 7);
        sz = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
        flt = 1'b1; cs = 2'd0; lat = 1; ld = prev; nword = word; nw = 0;
        if (bf) cs = 2'd2;
        else if (a % sz != 0) cs = 2'd1;
        else if (a >= 32768) cs = 2'd3;
        else begin
            flt = 1'b0;
            off = a % 4;
            full = (sz == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * sz)) - 32'd1;
            mask = full << (8 * off);
            if (!st) begin
                lat = 2;
                lane = (word >> (8 * off)) & full;
                if (f3 < 4 && sz < 4 && lane[8 * sz - 1]) lane = lane | ~full;
                ld = lane;
            end else begin
                lat = (sz == 4) ? 2 : 3;
                nword = (word & ~mask) | ((sd << (8 * off)) & mask);
                nw = 1;
            end
        end
    endfunction

    task automatic run_req(
        input  logic st, input logic [2:0] f3,
        input  logic [31:0] a, input logic [31:0] sd, input bit hold,
        output int lat, output logic flt, output logic [1:0] cs,
        output logic [31:0] ld, output int nw);
        int k;
        bit got;
        lat = -1; flt = 1'b0; cs = 2'd0; ld = 32'h0; nw = 0;
        got = 1'b0; k = 0;
        @(posedge clk); #1;
        while (!o_Ready && k < 10) begin
            @(posedge clk); #1;
            k++;
        end
        if (!o_Ready) begin
            total++; bad++;
            $display("FAIL ready_timeout: got 0 want 1");
        end
        i_Valid = 1'b1; i_IsStore = st; i_Funct3 = f3;
        i_Address = a; i_StoreData = sd;
        nreq++;
        @(posedge clk); #1;
        if (!hold) i_Valid = 1'b0;
        for (int c = 1; c <= 8 && !got; c++) begin
            @(negedge clk);
            if (o_Ready) ready_busy++;
            if (o_MemWriteEnable) begin
                mem[o_MemAddress[14:2]] = o_MemDataOut;
                nw++;
            end
            if (o_Done) begin
                got = 1'b1; lat = c; flt = o_Fault;
                cs = o_FaultCause; ld = o_LoadData;
            end
        end
    endtask

    task automatic do_check(input string tag, input logic st,
                            input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] sd, input bit hold);
        int lat, elat, nw, enw;
        logic flt, eflt;
        logic [1:0] cs, ecs;
        logic [31:0] ld, eld, eword, word;
        word = mem[a[14:2]];
        ref_model(st, f3, a, sd, word, last_ld, elat, eflt, ecs, eld, eword, enw);
        run_req(st, f3, a, sd, hold, lat, flt, cs, ld, nw);
        chk({tag, ".lat"}, 32'(lat), 32'(elat));
        chk({tag, ".fault"}, {31'h0, flt}, {31'h0, eflt});
        chk({tag, ".cause"}, {30'h0, cs}, {30'h0, ecs});
        chk({tag, ".ldata"}, ld, eld);
        chk({tag, ".word"}, mem[a[14:2]], eword);
        chk({tag, ".writes"}, 32'(nw), 32'(enw));
        last_ld = eld;
    endtask

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] sd;
        logic [31:0] init;
        int          lat;
        logic        flt;
        logic [1:0]  cs;
        logic [31:0] ld;
        logic [31:0] word;
        int          nw;
    } vec_t;

    vec_t vt [16];

    initial begin
        int lat, nw, dones;
        logic flt;
        logic [1:0] cs;
        logic [31:0] ld;

        vt[0]  = '{0, 3'b000, 32'h103, 0, 32'h80FF7F01, 2, 0, 0, 32'hFFFFFF80, 32'h80FF7F01, 0};
        vt[1]  = '{0, 3'b100, 32'h101, 0, 32'h80FF7F01, 2, 0, 0, 32'h0000007F, 32'h80FF7F01, 0};
        vt[2]  = '{0, 3'b001, 32'h102, 0, 32'h80FF7F01, 2, 0, 0, 32'hFFFF80FF, 32'h80FF7F01, 0};
        vt[3]  = '{0, 3'b101, 32'h100, 0, 32'h80FF7F01, 2, 0, 0, 32'h00007F01, 32'h80FF7F01, 0};
        vt[4]  = '{0, 3'b010, 32'h100, 0, 32'h80FF7F01, 2, 0, 0, 32'h80FF7F01, 32'h80FF7F01, 0};
        vt[5]  = '{1, 3'b000, 32'h202, 32'hAB, 32'h11223344, 3, 0, 0, 32'h80FF7F01, 32'h11AB3344, 1};
        vt[6]  = '{1, 3'b001, 32'h200, 32'hBEEF, 32'h11223344, 3, 0, 0, 32'h80FF7F01, 32'h1122BEEF, 1};
        vt[7]  = '{1, 3'b010, 32'h202, 32'hDEADBEEF, 32'h11223344, 1, 1, 1, 32'h80FF7F01, 32'h11223344, 0};
        vt[8]  = '{0, 3'b011, 32'h100, 0, 32'h80FF7F01, 1, 1, 2, 32'h80FF7F01, 32'h80FF7F01, 0};
        vt[9]  = '{0, 3'b010, 32'h8000, 0, 32'h0, 1, 1, 3, 32'h80FF7F01, 32'h0, 0};
        vt[10] = '{1, 3'b010, 32'h204, 32'hDEADBEEF, 32'h0, 2, 0, 0, 32'h80FF7F01, 32'hDEADBEEF, 1};
        vt[11] = '{1, 3'b011, 32'h8001, 0, 32'h0, 1, 1, 2, 32'h80FF7F01, 32'h0, 0};
        vt[12] = '{0, 3'b001, 32'h9001, 0, 32'h0, 1, 1, 1, 32'h80FF7F01, 32'h0, 0};
        vt[13] = '{0, 3'b010, 32'h7FFC, 0, 32'h12345678, 2, 0, 0, 32'h12345678, 32'h12345678, 0};
        vt[14] = '{0, 3'b000, 32'h7FFF, 0, 32'h12345678, 2, 0, 0, 32'h00000012, 32'h12345678, 0};
        vt[15] = '{1, 3'b000, 32'h7FFD, 32'h12345699, 32'h12345678, 3, 0, 0, 32'h00000012, 32'h12349978, 1};

        for (int i = 0; i < 8192; i++) mem[i] = 32'h0;

        #1 rst = 1'b1;
        #1;
        chk("rst.ready", {31'h0, o_Ready}, 32'h0);
        chk("rst.done", {31'h0, o_Done}, 32'h0);
        chk("rst.fault", {30'h0, o_FaultCause, o_Fault}, 32'h0);
        chk("rst.ldata", o_LoadData, 32'h0);
        chk("rst.en", {30'h0, o_MemReadEnable, o_MemWriteEnable}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst.ready_after", {31'h0, o_Ready}, 32'h1);
        chk("mode", {29'h0, o_MemMode}, 32'h2);

        for (int i = 0; i < 16; i++) begin
            mem[vt[i].a[14:2]] = vt[i].init;
            run_req(vt[i].st, vt[i].f3, vt[i].a, vt[i].sd, 1'b0,
                    lat, flt, cs, ld, nw);
            chk($sformatf("vec%0d.lat", i), 32'(lat), 32'(vt[i].lat));
            chk($sformatf("vec%0d.fault", i), {31'h0, flt}, {31'h0, vt[i].flt});
            chk($sformatf("vec%0d.cause", i), {30'h0, cs}, {30'h0, vt[i].cs});
            chk($sformatf("vec%0d.ldata", i), ld, vt[i].ld);
            chk($sformatf("vec%0d.word", i), mem[vt[i].a[14:2]], vt[i].word);
            chk($sformatf("vec%0d.writes", i), 32'(nw), 32'(vt[i].nw));
        end
        last_ld = 32'h00000012;

        // Reset while the read half of an RMW is in flight.
        mem[32'h300 >> 2] = 32'h0;
        @(posedge clk); #1;
        i_Valid = 1'b1; i_IsStore = 1'b1; i_Funct3 = 3'b000;
        i_Address = 32'h300; i_StoreData = 32'hFF;
        nreq++;
        @(posedge clk); #1;
        i_Valid = 1'b0;
        chk("abort.rd_before", {31'h0, o_MemReadEnable}, 32'h1);
        rst = 1'b1;
        #1;
        chk("abort.en_drop", {30'h0, o_MemReadEnable, o_MemWriteEnable}, 32'h0);
        chk("abort.ready_in_rst", {31'h0, o_Ready}, 32'h0);
        dones = 0;
        repeat (3) begin
            @(negedge clk);
            if (o_Done || o_MemWriteEnable) dones++;
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (o_Done || o_MemWriteEnable) dones++;
        end
        chk("abort.no_done", 32'(dones), 32'h0);
        chk("abort.word", mem[32'h300 >> 2], 32'h0);
        chk("abort.ready_after", {31'h0, o_Ready}, 32'h1);
        chk("abort.ldata", o_LoadData, 32'h0);
        last_ld = 32'h0;

        // Back-to-back with i_Valid held high.
        mem[32'h400 >> 2] = 32'hCAFEF00D;
        mem[32'h404 >> 2] = 32'h01020304;
        do_check("b2b0", 1'b0, 3'b010, 32'h400, 32'h0, 1'b1);
        do_check("b2b1", 1'b1, 3'b000, 32'h405, 32'h5A, 1'b1);
        do_check("b2b2", 1'b1, 3'b010, 32'h406, 32'h1, 1'b1);
        do_check("b2b3", 1'b0, 3'b001, 32'h406, 32'h0, 1'b1);
        do_check("b2b4", 1'b1, 3'b001, 32'h404, 32'h7777, 1'b1);
        i_Valid = 1'b0;

        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            logic [2:0] f3;
            logic st;
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) a = 32'h8000 + $urandom_range(0, 4095);
            else a = 32'($urandom_range(0, 32767));
            if ($urandom_range(0, 1) == 1) a = {a[31:2], 2'b00};
            mem[a[14:2]] = $urandom;
            do_check($sformatf("rnd%0d", i), st, f3, a, $urandom, 1'b0);
        end

        @(negedge clk);
        chk("both_enables", 32'(both_hi), 32'h0);
        chk("ready_while_busy", 32'(ready_busy), 32'h0);
        chk("accept_count", 32'(accepts), 32'(nreq));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
